// File: rtl/step_silencer.sv
// Per-transducer slew limiter: moves each transducer's intensity and phase toward
// its target by at most a programmable step per frame, with 2-cycle latency.
module step_silencer #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [15:0] UPDATE_RATE_INTENSITY,
  input  logic [15:0] UPDATE_RATE_PHASE,
  input  logic        DIN_VALID,
  input  logic [7:0]  INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  output logic [7:0]  INTENSITY_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic        DOUT_VALID,
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            accept;

  logic            s1_valid_q, s1_en_q;
  logic [15:0]     s1_rate_i_q, s1_rate_p_q;
  logic [7:0]      s1_tgt_i_q, s1_tgt_p_q;
  logic [AW-1:0]   s1_addr_q;

  logic [15:0]     mem_i [DEPTH];
  logic [15:0]     mem_p [DEPTH];
  logic [15:0]     cur_i_q, cur_p_q;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [15:0]     mem_wi, mem_wp;

  logic [15:0]     tgt_i, tgt_p, new_i, new_p, d_p;
  logic [16:0]     d_i, mag_i, mag_p;

  assign accept = DIN_VALID && (state_q == ST_RUN);
  assign BUSY   = (state_q == ST_INIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_INIT: begin
        clr_d = clr_q + AW'(1);
        if (clr_q == LAST) begin
          state_d = ST_RUN;
          clr_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) addr_d = (addr_q == LAST) ? '0 : addr_q + AW'(1);
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_INIT;
      clr_q       <= '0;
      addr_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_rate_i_q <= '0;
      s1_rate_p_q <= '0;
      s1_tgt_i_q  <= '0;
      s1_tgt_p_q  <= '0;
      s1_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      addr_q      <= addr_d;
      s1_valid_q  <= accept;
      s1_en_q     <= ENABLE;
      s1_rate_i_q <= UPDATE_RATE_INTENSITY;
      s1_rate_p_q <= UPDATE_RATE_PHASE;
      s1_tgt_i_q  <= INTENSITY_IN;
      s1_tgt_p_q  <= PHASE_IN;
      s1_addr_q   <= addr_q;
    end
  end

  // Intensity: signed 17-bit distance; clamp the step so it never overshoots.
  always_comb begin
    tgt_i = {s1_tgt_i_q, 8'h00};
    tgt_p = {s1_tgt_p_q, 8'h00};
    d_i   = {1'b0, tgt_i} - {1'b0, cur_i_q};
    mag_i = d_i[16] ? 17'(~d_i + 17'd1) : d_i;
    d_p   = tgt_p - cur_p_q;
    mag_p = d_p[15] ? (17'h10000 - {1'b0, d_p}) : {1'b0, d_p};
    new_i = tgt_i;
    new_p = tgt_p;
    if (s1_en_q) begin
      if (mag_i > {1'b0, s1_rate_i_q})
        new_i = d_i[16] ? cur_i_q - s1_rate_i_q : cur_i_q + s1_rate_i_q;
      // Exactly-opposite phase (d = -32768) has bit 15 set, so it steps downward.
      if (mag_p > {1'b0, s1_rate_p_q})
        new_p = d_p[15] ? cur_p_q - s1_rate_p_q : cur_p_q + s1_rate_p_q;
    end
  end

  always_comb begin
    mem_we    = (state_q == ST_INIT) || s1_valid_q;
    mem_waddr = (state_q == ST_INIT) ? clr_q : s1_addr_q;
    mem_wi    = (state_q == ST_INIT) ? 16'h0000 : new_i;
    mem_wp    = (state_q == ST_INIT) ? 16'h0000 : new_p;
  end

  // NOTE: the state memory has no reset; INIT clears it by walking every address.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_i[mem_waddr] <= mem_wi;
      mem_p[mem_waddr] <= mem_wp;
    end
    cur_i_q <= mem_i[addr_q];
    cur_p_q <= mem_p[addr_q];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INTENSITY_OUT <= '0;
      PHASE_OUT     <= '0;
      DOUT_VALID    <= 1'b0;
    end else begin
      DOUT_VALID <= s1_valid_q;
      if (s1_valid_q) begin
        INTENSITY_OUT <= new_i[15:8];
        PHASE_OUT     <= new_p[15:8];
      end
    end
  end

endmodule

// File: tb/tb_step_silencer.sv
// Randomized bench for step_silencer against an arithmetic per-transducer slew model.
module tb_step_silencer;

  localparam int DEPTH = 249;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] UPDATE_RATE_INTENSITY = '0;
  logic [15:0] UPDATE_RATE_PHASE = '0;
  logic        DIN_VALID = 1'b0;
  logic [7:0]  INTENSITY_IN = '0;
  logic [7:0]  PHASE_IN = '0;
  logic [7:0]  INTENSITY_OUT, PHASE_OUT;
  logic        DOUT_VALID, BUSY;

  step_silencer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY),
    .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
    .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
    .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT),
    .DOUT_VALID(DOUT_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current 8.8 values per transducer, plus a 2-deep output delay line.
  typedef struct { bit v; int i; int p; int addr; } beat_t;
  int    m_i [DEPTH];
  int    m_p [DEPTH];
  int    m_beat;
  int    m_init_left;
  beat_t m_p1, m_out;

  int got_i [DEPTH];
  int got_p [DEPTH];

  function automatic int limit(int cur, int d, int rate);
    if (d <= rate && d >= -rate) return cur + d;
    return (d < 0) ? cur - rate : cur + rate;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) begin m_i[k] = 0; m_p[k] = 0; end
    m_beat = 0;
    m_init_left = DEPTH;
    m_p1 = '{0, 0, 0, 0};
    m_out = '{0, 0, 0, 0};
  endfunction

  function automatic void model_edge(bit v, int ti, int tp, bit en, int ri, int rp);
    bit acc;
    int d;
    acc = v && (m_init_left == 0);
    if (m_init_left > 0) m_init_left--;
    m_out = m_p1;
    m_p1.v = acc;
    if (acc) begin
      if (en) begin
        m_i[m_beat] = limit(m_i[m_beat], ti * 256 - m_i[m_beat], ri);
        d = (tp * 256 - m_p[m_beat]) & 16'hFFFF;
        if (d >= 32768) d -= 65536;
        m_p[m_beat] = limit(m_p[m_beat], d, rp) & 16'hFFFF;
      end else begin
        m_i[m_beat] = ti * 256;
        m_p[m_beat] = tp * 256;
      end
      m_p1.i = m_i[m_beat];
      m_p1.p = m_p[m_beat];
      m_p1.addr = m_beat;
      m_beat = (m_beat + 1) % DEPTH;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] ti, input logic [7:0] tp,
                      input logic en, input logic [15:0] ri, input logic [15:0] rp);
    DIN_VALID = v; INTENSITY_IN = ti; PHASE_IN = tp; ENABLE = en;
    UPDATE_RATE_INTENSITY = ri; UPDATE_RATE_PHASE = rp;
    @(posedge CLK);
    model_edge(v, int'(ti), int'(tp), en, int'(ri), int'(rp));
    @(negedge CLK);
    check("busy", BUSY, m_init_left > 0);
    check("dout_valid", DOUT_VALID, m_out.v);
    if (m_out.v) begin
      check("intensity_out", INTENSITY_OUT, m_out.i >> 8);
      check("phase_out", PHASE_OUT, m_out.p >> 8);
      got_i[m_out.addr] = int'(INTENSITY_OUT);
      got_p[m_out.addr] = int'(PHASE_OUT);
    end
  endtask

  // Stimulus configuration shared by send_frame.
  logic [7:0]  tgt_i [DEPTH];
  logic [7:0]  tgt_p [DEPTH];
  int          en_cut;
  logic [15:0] ri, rp;
  int          gap_pct;

  task automatic idle();
    step(1'b0, 8'($urandom), 8'($urandom), 1'b1, ri, rp);
  endtask

  task automatic send_frame();
    for (int k = 0; k < DEPTH; k++) begin
      while (int'($urandom_range(99)) < gap_pct) idle();
      step(1'b1, tgt_i[k], tgt_p[k], k < en_cut, ri, rp);
    end
    idle();
    idle();
  endtask

  task automatic do_init();
    int n = 0;
    while (BUSY && n < 1000) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'b1, ri, rp);
      n++;
    end
    check("init_cycles", n, DEPTH);
  endtask

  task automatic randomize_targets();
    for (int k = 0; k < DEPTH; k++) begin
      tgt_i[k] = 8'($urandom);
      tgt_p[k] = 8'($urandom);
    end
  endtask

  int exp_ph [7] = '{8'h06, 8'h02, 8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hF0};

  initial begin
    model_reset();
    ri = 16'h1000; rp = 16'h0000; gap_pct = 0; en_cut = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin tgt_i[k] = 0; tgt_p[k] = 0; end

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_int", INTENSITY_OUT, 0);
    check("rst_ph", PHASE_OUT, 0);
    check("rst_valid", DOUT_VALID, 0);
    check("rst_busy", BUSY, 1);
    RST = 1'b0;
    do_init();
    send_frame();

    // Intensity slew on transducer 5.
    tgt_i[5] = 8'hFF;
    for (int f = 0; f < 17; f++) begin
      send_frame();
      check("slew_t5", got_i[5], (f < 15) ? 16 * (f + 1) : 255);
      check("slew_t4", got_i[4], 0);
    end

    // Phase shortest path: establish 0x0A00 / 0x0000 in bypass, then limit.
    tgt_p[7] = 8'h0A; tgt_p[8] = 8'h00; en_cut = 0;
    send_frame();
    tgt_p[7] = 8'hF0; tgt_p[8] = 8'h80; en_cut = DEPTH; rp = 16'h0400;
    for (int f = 0; f < 7; f++) begin
      send_frame();
      check("phase_t7", got_p[7], exp_ph[f]);
      if (f == 0) check("phase_t8_opposite", got_p[8], 8'hFC);
    end

    // Bypass from beat 100, then limiting resumes from those targets.
    randomize_targets();
    ri = 16'h0800; rp = 16'h0800; en_cut = 100;
    send_frame();
    check("bypass_i100", got_i[100], tgt_i[100]);
    check("bypass_p180", got_p[180], tgt_p[180]);
    check("bypass_i248", got_i[248], tgt_i[248]);
    en_cut = DEPTH;
    send_frame();
    check("resume_i150", got_i[150], tgt_i[150]);
    check("resume_p200", got_p[200], tgt_p[200]);

    // Random gaps, targets and rates across 3 frames, then the wrap to transducer 0.
    gap_pct = 30;
    for (int f = 0; f < 3; f++) begin
      randomize_targets();
      ri = 16'($urandom_range(0, 16'h3000));
      rp = 16'($urandom_range(0, 16'h3000));
      en_cut = (f == 1) ? int'($urandom_range(0, DEPTH)) : DEPTH;
      send_frame();
    end
    gap_pct = 0;
    step(1'b1, 8'hAB, 8'h12, 1'b0, ri, rp);
    idle();
    idle();
    check("wrap_t0_i", got_i[0], 8'hAB);
    check("wrap_t0_p", got_p[0], 8'h12);

    // Reset mid-frame at beat 120.
    randomize_targets();
    ri = 16'h1000; rp = 16'h1000;
    for (int k = 0; k < 120; k++) step(1'b1, tgt_i[k], tgt_p[k], 1'b1, ri, rp);
    #2 RST = 1'b1;
    #1;
    check("midrst_int", INTENSITY_OUT, 0);
    check("midrst_ph", PHASE_OUT, 0);
    check("midrst_valid", DOUT_VALID, 0);
    check("midrst_busy", BUSY, 1);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    do_init();
    for (int k = 0; k < DEPTH; k++) begin tgt_i[k] = 0; tgt_p[k] = 0; end
    tgt_i[5] = 8'hFF; tgt_p[6] = 8'h40;
    send_frame();
    check("post_rst_t5", got_i[5], 8'h10);
    check("post_rst_t6", got_p[6], 8'h10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/step_silencer.md
# step_silencer

Per-transducer slew limiter that sits directly downstream of the STM stage. It consumes the DEPTH-beat stream of intensity/phase values produced on each STM update. Each transducer's intensity and phase move toward their new targets by at most a programmable step per frame, with phase taking the shortest circular path. It re-emits the limited stream with the same beat order and a fixed 2-cycle latency.

## Interface
Parameters:
- DEPTH, 249, number of transducers (beats per frame); must be ≥ 2.

Ports (name, direction, width, meaning):
- CLK, in, 1, sole clock.
- RST, in, 1, reset; asynchronous, active-high.
- ENABLE, in, 1, 1 = limit; 0 = bypass (output = target, state overwritten with target).
- UPDATE_RATE_INTENSITY, in, 16, max intensity step per frame in 8.8 fixed point.
- UPDATE_RATE_PHASE, in, 16, max phase step per frame in 8.8 fixed point.
- DIN_VALID, in, 1, input beat strobe.
- INTENSITY_IN, in, 8, target intensity.
- PHASE_IN, in, 8, target phase (circular, 256 = 2π).
- INTENSITY_OUT, out, 8, limited intensity.
- PHASE_OUT, out, 8, limited phase.
- DOUT_VALID, out, 1, output beat strobe.
- BUSY, out, 1, high while state memory is being cleared.

## Operation
- State memory holds two 16-bit 8.8 entries per transducer: cur_i and cur_p. It has DEPTH entries, one read and one write per cycle.
- FSM states:
  - INIT: a clear counter walks addresses 0..DEPTH-1, writing 0 to both entries. BUSY=1. DIN_VALID beats are dropped, with no output. On the last address, go to RUN.
  - RUN: the beat address counter starts at 0. It increments on each accepted DIN_VALID and wraps DEPTH-1 → 0. Gaps (DIN_VALID=0) hold the counter.
- Per accepted beat at address a, with T_i = INTENSITY_IN<<8 and T_p = PHASE_IN<<8:
  - Intensity:
    - d = T_i − cur_i, signed 17-bit.
    - If |d| ≤ UPDATE_RATE_INTENSITY, the new value is T_i.
    - Otherwise the new value is cur_i + sign(d)·UPDATE_RATE_INTENSITY. This never overshoots.
  - Phase:
    - d = (T_p − cur_p) mod 2^16, read as signed 16-bit.
    - If |d| ≤ UPDATE_RATE_PHASE, the new value is T_p.
    - Otherwise the new value is (cur_p + sign(d)·UPDATE_RATE_PHASE) mod 2^16.
    - For d = −32768 (exactly opposite), the step is negative.
  - A rate of 0 freezes the value unless d = 0.
  - ENABLE=0: the new value is the target.
  - The new values are written back to address a. Outputs are new_i[15:8] and new_p[15:8] (truncation).
- ENABLE and both rates are sampled per beat, together with the data in stage 1. A mid-frame change applies from that beat onward.

## Timing
- Reset values: INTENSITY_OUT=0, PHASE_OUT=0, DOUT_VALID=0, BUSY=1, FSM=INIT, clear counter 0, beat counter 0.
- RST asserted mid-operation immediately forces the reset values. In-flight beats are lost and INIT reruns after deassertion.
- INIT lasts exactly DEPTH cycles after RST deassertion. BUSY falls in the same cycle the FSM enters RUN. A beat presented in that cycle is accepted.
- Pipeline:
  - Stage 1 (cycle t, DIN_VALID=1): register the input and read memory[a].
  - Stage 2 (t+1): compute and write memory[a].
  - Outputs are registered: DOUT_VALID=1 with data at t+2.
- Throughput is 1 beat/cycle. Gaps propagate unchanged (DOUT_VALID mirrors DIN_VALID delayed by 2 cycles).
- No read/write hazard: the same address recurs at the earliest DEPTH ≥ 2 beats later, after write-back.

## Test plan
- Reset then INIT:
  - Stimulus: deassert RST.
  - Required: BUSY high for exactly 249 cycles; beats driven during INIT produce no DOUT_VALID.
  - Stimulus: then drive a frame of 249 beats with intensity 0 and ENABLE=1.
  - Required: all outputs 0, DOUT_VALID 2 cycles after each input beat.
- Intensity slew:
  - Stimulus: rate_i=0x1000; repeated frames with target 0xFF on transducer 5.
  - Required: outputs 0x10, 0x20, …, 0xF0, then 0xFF on frame 16 and every frame after; other transducers unaffected.
- Phase shortest path:
  - Stimulus: cur_p = 0x0A00 (established with ENABLE=0); target 0xF0; rate_p=0x0400.
  - Required: outputs 0x06, 0x02, 0xFE, 0xFA, 0xF6, 0xF2, 0xF0 (wraps downward).
  - Stimulus: start at 0x0000, target 0x80.
  - Required: steps negative (first output 0xFC).
- Bypass and mid-frame change:
  - Stimulus: ENABLE toggled 1→0 at beat 100 of a frame.
  - Required: beats 0–99 slewed; beats 100–248 equal their targets; the next frame with ENABLE=1 starts from those targets.
- Gaps and wrap:
  - Stimulus: random DIN_VALID gaps across 3 frames.
  - Required: the address counter maps beat k of each frame to transducer k, and the 250th accepted beat updates transducer 0.
- Reset mid-frame:
  - Stimulus: assert RST at beat 120.
  - Required: outputs 0 immediately; INIT reruns; the next frame slews from 0.
